// File: rtl/apb_ahblite_bridge.sv
// APB completer that replays each APB transfer as one AHB-Lite SINGLE transfer.
// Optional APB2AHB_STRB_CHECK_EN rejects writes with non-contiguous/unaligned PSTRB.
module apb_ahblite_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic                    PREADY,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PSLVERR,
   output logic [ADDR_WIDTH-1:0]   HADDR,
   output logic [1:0]              HTRANS,
   output logic                    HWRITE,
   output logic [2:0]              HSIZE,
   output logic [2:0]              HBURST,
   output logic [3:0]              HPROT,
   output logic                    HMASTLOCK,
   output logic [DATA_WIDTH-1:0]   HWDATA,
   input  logic [DATA_WIDTH-1:0]   HRDATA,
   input  logic                    HREADY,
   input  logic                    HRESP
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   typedef struct packed {
      logic [2:0] size;
      logic [1:0] off;
      logic       ok;
   } dec_t;

   state_t                  state, state_nxt;
   dec_t                    dec;
   logic                    setup;
   logic                    err, err_d;
   logic                    pready_d, pslverr_d, hwrite_d;
   logic [DATA_WIDTH-1:0]   prdata_d, hwdata_d;
   logic [ADDR_WIDTH-1:0]   haddr_d;
   logic [1:0]              htrans_d;
   logic [2:0]              hsize_d;
   logic [3:0]              hprot_d;
   logic                    unused_ok;

   assign setup     = PSEL & ~PENABLE;
   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;

   // Size/offset from the strobe pattern; reads are always aligned words.
   always_comb begin
      dec = '{size: 3'b010, off: 2'b00, ok: 1'b1};
      if (PWRITE) begin
         case (PSTRB)
            4'b0001: dec = '{size: 3'b000, off: 2'b00, ok: 1'b1};
            4'b0010: dec = '{size: 3'b000, off: 2'b01, ok: 1'b1};
            4'b0100: dec = '{size: 3'b000, off: 2'b10, ok: 1'b1};
            4'b1000: dec = '{size: 3'b000, off: 2'b11, ok: 1'b1};
            4'b0011: dec = '{size: 3'b001, off: 2'b00, ok: 1'b1};
            4'b1100: dec = '{size: 3'b001, off: 2'b10, ok: 1'b1};
            4'b1111: dec = '{size: 3'b010, off: 2'b00, ok: 1'b1};
            default: dec = '{size: 3'b010, off: 2'b00, ok: 1'b0};
         endcase
      end
   end

`ifdef APB2AHB_STRB_CHECK_EN
   logic bad_strb;
   assign bad_strb  = PWRITE & ~dec.ok;
   assign unused_ok = ^{PADDR[1:0], PPROT[1]};
`else
   assign unused_ok = ^{PADDR[1:0], PPROT[1], dec.ok};
`endif

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state   <= IDLE;
         err     <= 1'b0;
         PREADY  <= 1'b0;
         PRDATA  <= '0;
         PSLVERR <= 1'b0;
         HTRANS  <= 2'b00;
         HADDR   <= '0;
         HWRITE  <= 1'b0;
         HSIZE   <= 3'b000;
         HPROT   <= 4'b0000;
         HWDATA  <= '0;
      end else begin
         state   <= state_nxt;
         err     <= err_d;
         PREADY  <= pready_d;
         PRDATA  <= prdata_d;
         PSLVERR <= pslverr_d;
         HTRANS  <= htrans_d;
         HADDR   <= haddr_d;
         HWRITE  <= hwrite_d;
         HSIZE   <= hsize_d;
         HPROT   <= hprot_d;
         HWDATA  <= hwdata_d;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (setup) begin
`ifdef APB2AHB_STRB_CHECK_EN
            state_nxt = bad_strb ? DONE : ADDR;
`else
            state_nxt = ADDR;
`endif
         end
         ADDR: if (HREADY) state_nxt = DATA;
         DATA: if (HREADY) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs, keyed on the upcoming state.
   always_comb begin
      htrans_d  = 2'b00;
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      haddr_d   = HADDR;
      hwrite_d  = HWRITE;
      hsize_d   = HSIZE;
      hprot_d   = HPROT;
      hwdata_d  = HWDATA;
      err_d     = err;
      if (state == IDLE && setup) begin
         haddr_d  = {PADDR[ADDR_WIDTH-1:2], dec.off};
         hwrite_d = PWRITE;
         hsize_d  = dec.size;
         hprot_d  = {2'b00, PPROT[0], ~PPROT[2]};
         hwdata_d = PWDATA;
`ifdef APB2AHB_STRB_CHECK_EN
         if (bad_strb) err_d = 1'b1;
`endif
      end
      if (state == DATA) err_d = err | HRESP;
      if (state == DONE) err_d = 1'b0;
      if (state_nxt == ADDR) htrans_d = 2'b10;
      if (state_nxt == DONE) begin
         pready_d  = 1'b1;
         pslverr_d = err_d;
         prdata_d  = (err_d | hwrite_d) ? '0 : HRDATA;
      end
   end

endmodule
